cr_crc_chk: RTL and testbench

Receive-side CRC checker, the counterpart of the streaming CRC generator. It consumes a framed 64-bit byte stream whose last four bytes are a CRC32C trailer. It forwards the payload with the trailer stripped, recomputes the CRC over the payload, and reports per-frame pass/fail, runt and protocol errors. It sits at the ingress of decompression/engine datapaths, behind the bus adapter.

---
 rtl/cr_crc_pkg.sv | 32 +++
 rtl/cr_crc_calc.sv | 39 +++
 rtl/cr_crc_chk.sv | 154 +++++++++++++++
 tb/tb_cr_crc_chk.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cr_crc_pkg.sv
// rtl/cr_crc_pkg.sv - shared types and helpers for the receive-side CRC checker
package cr_crc_pkg;

  localparam logic [3:0] TRAILER_BYTES = 4'd4;

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_FLUSH} crc_chk_state_e;

  // Reflected CRC update over one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b,
                                             input logic [31:0] poly);
    logic [31:0] c;
    c = crc ^ {24'd0, b};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ poly) : (c >> 1);
    return c;
  endfunction

  function automatic logic [3:0] vbytes_to_count(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
    return n;
  endfunction

  function automatic logic vbytes_is_therm(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v + 8'd1)) == 8'h00);
  endfunction

  function automatic logic [7:0] count_to_vbytes(input logic [3:0] n);
    return 8'((9'd1 << n) - 9'd1);
  endfunction

endpackage

// File: rtl/cr_crc_calc.sv
// rtl/cr_crc_calc.sv - CRC register with seed load and byte-count-qualified update
module cr_crc_calc
  import cr_crc_pkg::*;
#(
  parameter logic [31:0] POLYNOMIAL   = 32'h82F63B78,
  parameter int          N_DATA_WIDTH = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    load_i,
  input  logic [31:0]             seed_i,
  input  logic                    upd_i,
  input  logic [N_DATA_WIDTH-1:0] data_i,
  input  logic [3:0]              cnt_i,
  output logic [31:0]             crc_o,
  output logic [31:0]             crc_next_o
);

  logic [31:0] crc_q, crc_d;

  // Seed and update may coincide, so the update starts from the seed in that case.
  always_comb begin
    crc_d = load_i ? seed_i : crc_q;
    if (upd_i) begin
      for (int i = 0; i < N_DATA_WIDTH / 8; i++) begin
        if (i < int'(cnt_i)) crc_d = crc32_byte(crc_d, data_i[8*i +: 8], POLYNOMIAL);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) crc_q <= 32'hFFFFFFFF;
    else       crc_q <= crc_d;
  end

  assign crc_o      = crc_q;
  assign crc_next_o = crc_d;

endmodule

// File: rtl/cr_crc_chk.sv
// rtl/cr_crc_chk.sv - receive CRC checker: strips the CRC32C trailer and reports frame status
module cr_crc_chk
  import cr_crc_pkg::*;
#(
  parameter logic [31:0] POLYNOMIAL     = 32'h82F63B78,
  parameter int          N_CRC_WIDTH    = 32,
  parameter int          N_DATA_WIDTH   = 64,
  parameter int          N_VBYTES_WIDTH = N_DATA_WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               init_value,
  input  logic [N_DATA_WIDTH-1:0]   in_data,
  input  logic [N_VBYTES_WIDTH-1:0] in_vbytes,
  input  logic                      in_sof,
  input  logic                      in_eof,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [N_DATA_WIDTH-1:0]   out_data,
  output logic [N_VBYTES_WIDTH-1:0] out_vbytes,
  output logic                      out_sof,
  output logic                      out_eof,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      stat_valid,
  output logic                      stat_crc_ok,
  output logic                      stat_runt,
  output logic                      stat_proto_err,
  output logic [31:0]               stat_crc
);

  crc_chk_state_e state_q, state_d;
  logic [N_DATA_WIDTH-1:0]   hold_data_q, hold_data_d, out_data_q, out_data_d, e_data;
  logic [N_VBYTES_WIDTH-1:0] hold_vb_q, hold_vb_d, out_vb_q, out_vb_d, e_vb;
  logic                      hold_sof_q, hold_sof_d, out_sof_q, out_sof_d, out_eof_q, out_eof_d;
  logic                      out_valid_q, out_valid_d, e_sof, e_eof, emit, final_beat;
  logic [N_CRC_WIDTH-1:0]    trailer_q, trailer_d, trailer_c, final_trailer;
  logic                      stat_valid_q, stat_valid_d, stat_ok_q, stat_ok_d;
  logic                      stat_runt_q, stat_runt_d, stat_proto_q, stat_proto_d;
  logic [31:0]               stat_crc_q, stat_crc_d, pend_crc_q, pend_crc_d;
  logic                      pend_ok_q, pend_ok_d, crc_pend_q, crc_pend_d;
  logic                      acc, out_free, crc_done, err_proto, err_runt, crc_load, therm;
  logic [3:0]                n;
  logic [2*N_DATA_WIDTH-1:0] cat;
  logic [31:0]               crc_r, crc_next;

  assign in_ready = (state_q != ST_FLUSH) & (!out_valid_q | out_ready);
  assign acc      = in_valid & in_ready;
  assign out_free = !out_valid_q | out_ready;
  assign crc_done = out_valid_q & out_ready & out_eof_q;
  assign n        = vbytes_to_count(in_vbytes);
  assign therm    = vbytes_is_therm(in_vbytes);
  // The trailer always ends at the last valid byte of the eof beat, whether or not a beat is held.
  assign cat       = {in_data, hold_data_q};
  assign trailer_c = cat[{n, 3'b000} + 7'd32 +: N_CRC_WIDTH];

  cr_crc_calc #(.POLYNOMIAL(POLYNOMIAL), .N_DATA_WIDTH(N_DATA_WIDTH)) u_calc (
    .clk_i(clk), .rst_i(rst), .load_i(crc_load), .seed_i(init_value), .upd_i(emit),
    .data_i(e_data), .cnt_i(vbytes_to_count(e_vb)), .crc_o(crc_r), .crc_next_o(crc_next)
  );

  always_comb begin
    state_d = state_q;  hold_data_d = hold_data_q; hold_sof_d = hold_sof_q;
    hold_vb_d = hold_vb_q; trailer_d = trailer_q;
    out_data_d = out_data_q; out_vb_d = out_vb_q; out_sof_d = out_sof_q; out_eof_d = out_eof_q;
    out_valid_d = out_valid_q & !out_ready;
    emit = 1'b0; e_data = hold_data_q; e_vb = 8'hFF; e_sof = hold_sof_q; e_eof = 1'b0;
    final_beat = 1'b0; final_trailer = trailer_q; crc_load = 1'b0;
    err_proto = 1'b0; err_runt = 1'b0;
    case (state_q)
      ST_IDLE, ST_HOLD: if (acc) begin
        if (in_sof) begin
          err_proto = (state_q == ST_HOLD);
          crc_load  = 1'b1;
          if (!in_eof) begin
            hold_data_d = in_data; hold_sof_d = 1'b1; state_d = ST_HOLD;
          end else begin
            state_d = ST_IDLE;
            if (!therm) err_proto = 1'b1;
            else if (n <= TRAILER_BYTES) err_runt = 1'b1;
            else begin
              emit = 1'b1; e_data = in_data; e_vb = count_to_vbytes(n - TRAILER_BYTES);
              e_sof = 1'b1; e_eof = 1'b1; final_beat = 1'b1; final_trailer = trailer_c;
            end
          end
        end else if (state_q == ST_IDLE) begin
          err_proto = 1'b1;
        end else if (!in_eof) begin
          emit = 1'b1; hold_data_d = in_data; hold_sof_d = 1'b0;
        end else if (!therm) begin
          err_proto = 1'b1; state_d = ST_IDLE;
        end else if (n > TRAILER_BYTES) begin
          emit = 1'b1; hold_data_d = in_data; hold_sof_d = 1'b0;
          hold_vb_d = count_to_vbytes(n - TRAILER_BYTES); trailer_d = trailer_c; state_d = ST_FLUSH;
        end else begin
          emit = 1'b1; e_vb = count_to_vbytes(n + TRAILER_BYTES); e_eof = 1'b1;
          final_beat = 1'b1; final_trailer = trailer_c; state_d = ST_IDLE;
        end
      end
      ST_FLUSH: if (out_free) begin
        emit = 1'b1; e_vb = hold_vb_q; e_sof = 1'b0; e_eof = 1'b1; final_beat = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (emit) begin
      out_data_d = e_data; out_vb_d = e_vb; out_sof_d = e_sof; out_eof_d = e_eof;
      out_valid_d = 1'b1;
    end
    pend_ok_d = pend_ok_q; pend_crc_d = pend_crc_q;
    if (final_beat) begin
      pend_crc_d = ~crc_next; pend_ok_d = (~crc_next == final_trailer);
    end
    // Error pulses win a shared cycle; the frame's CRC result waits for the next free one.
    stat_valid_d = 1'b0; stat_ok_d = stat_ok_q; stat_runt_d = stat_runt_q;
    stat_proto_d = stat_proto_q; stat_crc_d = stat_crc_q; crc_pend_d = crc_pend_q;
    if (err_proto | err_runt) begin
      stat_valid_d = 1'b1; stat_ok_d = 1'b0; stat_runt_d = err_runt; stat_proto_d = err_proto;
      stat_crc_d = ~crc_r; crc_pend_d = crc_pend_q | crc_done;
    end else if (crc_done | crc_pend_q) begin
      stat_valid_d = 1'b1; stat_ok_d = pend_ok_q; stat_runt_d = 1'b0; stat_proto_d = 1'b0;
      stat_crc_d = pend_crc_q; crc_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE; hold_data_q <= '0; hold_sof_q <= 1'b0; hold_vb_q <= '0; trailer_q <= '0;
      out_data_q <= '0; out_vb_q <= '0; out_sof_q <= 1'b0; out_eof_q <= 1'b0; out_valid_q <= 1'b0;
      stat_valid_q <= 1'b0; stat_ok_q <= 1'b0; stat_runt_q <= 1'b0; stat_proto_q <= 1'b0;
      stat_crc_q <= '0; pend_ok_q <= 1'b0; pend_crc_q <= '0; crc_pend_q <= 1'b0;
    end else begin
      state_q <= state_d; hold_data_q <= hold_data_d; hold_sof_q <= hold_sof_d;
      hold_vb_q <= hold_vb_d; trailer_q <= trailer_d;
      out_data_q <= out_data_d; out_vb_q <= out_vb_d; out_sof_q <= out_sof_d;
      out_eof_q <= out_eof_d; out_valid_q <= out_valid_d;
      stat_valid_q <= stat_valid_d; stat_ok_q <= stat_ok_d; stat_runt_q <= stat_runt_d;
      stat_proto_q <= stat_proto_d; stat_crc_q <= stat_crc_d;
      pend_ok_q <= pend_ok_d; pend_crc_q <= pend_crc_d; crc_pend_q <= crc_pend_d;
    end
  end

  assign out_data       = out_data_q;
  assign out_vbytes     = out_vb_q;
  assign out_sof        = out_sof_q;
  assign out_eof        = out_eof_q;
  assign out_valid      = out_valid_q;
  assign stat_valid     = stat_valid_q;
  assign stat_crc_ok    = stat_ok_q;
  assign stat_runt      = stat_runt_q;
  assign stat_proto_err = stat_proto_q;
  assign stat_crc       = stat_crc_q;

endmodule

// File: tb/tb_cr_crc_chk.sv
// tb/tb_cr_crc_chk.sv - self-checking bench for cr_crc_chk
module tb_cr_crc_chk;

  localparam logic [31:0] POLY = 32'h82F63B78;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {logic [63:0] data; logic [7:0] vb; logic sof; logic eof;} beat_t;
  typedef struct {logic ok; logic [31:0] crc;} stat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] init_value = 32'hFFFFFFFF;
  logic [63:0] in_data = '0;
  logic [7:0]  in_vbytes = '0;
  logic        in_sof = 1'b0, in_eof = 1'b0, in_valid = 1'b0, in_ready;
  logic [63:0] out_data;
  logic [7:0]  out_vbytes;
  logic        out_sof, out_eof, out_valid, out_ready = 1'b1;
  logic        stat_valid, stat_crc_ok, stat_runt, stat_proto_err;
  logic [31:0] stat_crc;

  cr_crc_chk dut (
    .clk(clk), .rst(rst), .init_value(init_value), .in_data(in_data), .in_vbytes(in_vbytes),
    .in_sof(in_sof), .in_eof(in_eof), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_vbytes(out_vbytes), .out_sof(out_sof), .out_eof(out_eof),
    .out_valid(out_valid), .out_ready(out_ready), .stat_valid(stat_valid),
    .stat_crc_ok(stat_crc_ok), .stat_runt(stat_runt), .stat_proto_err(stat_proto_err),
    .stat_crc(stat_crc)
  );

  always #5 clk = ~clk;

  int    n_tests = 0, n_fail = 0;
  beat_t exp_beats[$];
  stat_t exp_stat[$];
  int    exp_runt = 0, exp_proto = 0;
  logic  bp_en = 1'b0;
  logic  last_ok, last_runt, last_proto;
  logic [31:0] last_crc;
  logic [7:0]  last_vb;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mask_bytes(input logic [63:0] d, input logic [7:0] vb);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = vb[i] ? d[8*i +: 8] : 8'h00;
    return m;
  endfunction

  // Reference CRC32C, bit-serial: returns the complemented (reported) CRC.
  function automatic logic [31:0] ref_crc(input byte_q_t bytes, input logic [31:0] seed);
    logic [31:0] c;
    logic        fb;
    c = seed;
    foreach (bytes[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ bytes[i][b];
        c  = c >> 1;
        if (fb) c = c ^ POLY;
      end
    end
    return ~c;
  endfunction

  // Output and status monitor
  initial begin
    beat_t e;
    stat_t s;
    forever begin
      @(posedge clk); #1;
      out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (!rst) begin
        if (out_valid && out_ready) begin
          if (exp_beats.size() == 0) check_eq("out_unexpected", 64'(exp_beats.size()), 64'd1);
          else begin
            e = exp_beats.pop_front();
            check_eq("out_data", mask_bytes(out_data, out_vbytes), mask_bytes(e.data, e.vb));
            check_eq("out_vbytes", 64'(out_vbytes), 64'(e.vb));
            check_eq("out_sof", 64'(out_sof), 64'(e.sof));
            check_eq("out_eof", 64'(out_eof), 64'(e.eof));
            last_vb = out_vbytes;
          end
        end
        if (stat_valid) begin
          if (stat_proto_err) begin
            check_eq("proto_expected", 64'(exp_proto > 0), 64'd1);
            if (exp_proto > 0) exp_proto--;
            last_proto = 1'b1;
          end else if (stat_runt) begin
            check_eq("runt_expected", 64'(exp_runt > 0), 64'd1);
            check_eq("runt_crc_ok", 64'(stat_crc_ok), 64'd0);
            if (exp_runt > 0) exp_runt--;
            last_runt = 1'b1;
          end else begin
            check_eq("stat_expected", 64'(exp_stat.size() > 0), 64'd1);
            if (exp_stat.size() > 0) begin
              s = exp_stat.pop_front();
              check_eq("stat_crc", 64'(stat_crc), 64'(s.crc));
              check_eq("stat_crc_ok", 64'(stat_crc_ok), 64'(s.ok));
            end
            last_ok  = stat_crc_ok;
            last_crc = stat_crc;
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send_beat(input logic [63:0] d, input logic [7:0] vb, input logic sof,
                           input logic eof);
    int   k;
    logic acc;
    in_data = d; in_vbytes = vb; in_sof = sof; in_eof = eof; in_valid = 1'b1;
    k = 0; acc = 1'b0;
    while (!acc && k < 2000) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; k++;
    end
    in_valid = 1'b0;
    check_eq("in_accept", 64'(acc), 64'd1);
  endtask

  task automatic send_frame(input byte_q_t payload, input logic [31:0] seed,
                            input logic [31:0] txor, input logic gaps);
    byte_q_t     fr;
    logic [31:0] c, t;
    logic [63:0] d;
    int          total, len, nb, cnt;
    beat_t       e;
    stat_t       s;
    c = ref_crc(payload, seed);
    t = c ^ txor;
    fr = payload;
    for (int k = 0; k < 4; k++) fr.push_back(t[8*k +: 8]);
    len = payload.size(); total = fr.size();
    if (total <= 4) exp_runt++;
    else begin
      for (int i = 0; i < len; i += 8) begin
        cnt = (len - i < 8) ? len - i : 8;
        d = '0;
        for (int k = 0; k < cnt; k++) d[8*k +: 8] = payload[i+k];
        e.data = d; e.vb = 8'((9'd1 << cnt) - 9'd1); e.sof = (i == 0); e.eof = (i + 8 >= len);
        exp_beats.push_back(e);
      end
      s.ok = (txor == 32'd0); s.crc = c;
      exp_stat.push_back(s);
    end
    nb = (total + 7) / 8;
    init_value = seed;
    for (int b = 0; b < nb; b++) begin
      cnt = (total - 8*b < 8) ? total - 8*b : 8;
      d = '0;
      for (int k = 0; k < cnt; k++) d[8*k +: 8] = fr[8*b+k];
      if (gaps && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      send_beat(d, 8'((9'd1 << cnt) - 9'd1), b == 0, b == nb - 1);
      if (b == nb - 1 && nb >= 2 && cnt > 4) begin
        @(negedge clk);
        check_eq("in_ready_flush", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_drain(input int limit);
    int k;
    k = 0;
    while ((exp_beats.size() != 0 || exp_stat.size() != 0 || exp_runt != 0 || exp_proto != 0)
           && k < limit) begin
      @(posedge clk); #1; k++;
    end
    check_eq("drain_beats", 64'(exp_beats.size()), 64'd0);
    check_eq("drain_status", 64'(exp_stat.size() + exp_runt + exp_proto), 64'd0);
  endtask

  function automatic byte_q_t rand_payload(input int len);
    byte_q_t p;
    for (int i = 0; i < len; i++) p.push_back(8'($urandom));
    return p;
  endfunction

  initial begin
    byte_q_t p;
    int      len;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_stat_valid", 64'(stat_valid), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_data", out_data, 64'd0);
    check_eq("rst_stat_crc", 64'(stat_crc), 64'd0);
    check_eq("rst_stat_flags", 64'({stat_crc_ok, stat_runt, stat_proto_err}), 64'd0);
    @(posedge clk); #1;

    p = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    last_vb = '0;
    send_frame(p, 32'hFFFFFFFF, 32'd0, 1'b0);
    wait_drain(200);
    check_eq("vec_crc", 64'(last_crc), 64'hE3069283);
    check_eq("vec_ok", 64'(last_ok), 64'd1);
    check_eq("vec_last_vb", 64'(last_vb), 64'h01);

    send_frame(p, 32'hFFFFFFFF, 32'h00000007, 1'b0);
    wait_drain(200);
    check_eq("bad_crc", 64'(last_crc), 64'hE3069283);
    check_eq("bad_ok", 64'(last_ok), 64'd0);

    send_frame(rand_payload(7), 32'($urandom), 32'd0, 1'b0);
    wait_drain(200);
    check_eq("split_vb", 64'(last_vb), 64'h7F);
    check_eq("split_ok", 64'(last_ok), 64'd1);

    last_runt = 1'b0;
    send_frame(rand_payload(0), 32'hFFFFFFFF, 32'd0, 1'b0);
    wait_drain(200);
    check_eq("runt_seen", 64'(last_runt), 64'd1);

    last_proto = 1'b0; last_ok = 1'b0;
    exp_proto++;
    send_beat(64'h0123456789ABCDEF, 8'hFF, 1'b1, 1'b0);
    send_frame(rand_payload(12), 32'hFFFFFFFF, 32'd0, 1'b0);
    wait_drain(200);
    check_eq("proto_seen", 64'(last_proto), 64'd1);
    check_eq("proto_next_ok", 64'(last_ok), 64'd1);

    bp_en = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      len = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 40));
      send_frame(rand_payload(len), 32'($urandom),
                 ($urandom_range(0, 7) == 0) ? (32'd1 << $urandom_range(0, 31)) : 32'd0, 1'b1);
    end
    wait_drain(5000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
